// File: rtl/instr_fetch.sv
// Instruction-issue stage: small on-chip program memory that holds each word on the CU bus
// for its type-specific cycle count. Optional wrap at end of memory: define FETCH_WRAP_EN.
module instr_fetch #(
  parameter int INSTR_WIDTH  = 20,
  parameter int PC_BITS      = 5,
  parameter int STD_CYCLES   = 3,
  parameter int LOAD_CYCLES  = 4,
  parameter int STORE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   prog_wen,
  input  logic [PC_BITS-1:0]     prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_BITS-1:0]     pc,
  output logic                   issue,
  output logic                   busy,
  output logic                   halted
);

  localparam int DEPTH = 1 << PC_BITS;
  localparam int CNT_W = 8;
`ifdef FETCH_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   issue_q, issue_d;
  logic                   halt_lat_q, halt_lat_d;

  logic [INSTR_WIDTH-1:0] imem [DEPTH];
  logic [PC_BITS-1:0]     next_pc;
  logic [PC_BITS-1:0]     rd_addr;
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic [1:0]             fetch_type;

  function automatic logic [CNT_W-1:0] hold_of(input logic [1:0] t);
    case (t)
      2'b01:   return CNT_W'(STD_CYCLES);
      2'b10:   return CNT_W'(LOAD_CYCLES);
      2'b11:   return CNT_W'(STORE_CYCLES);
      default: return '0;
    endcase
  endfunction

  // Program loads are only accepted while nothing is executing.
  always_ff @(posedge clk) begin
    if (prog_wen && state_q != S_RUN) imem[prog_addr] <= prog_data;
  end

  // pc+1 wraps to 0 at the top of memory, which is exactly the wrap-mode fetch address.
  assign next_pc    = pc_q + PC_BITS'(1);
  assign rd_addr    = (state_q == S_RUN) ? next_pc : '0;
  assign fetch_word = imem[rd_addr];
  assign fetch_type = fetch_word[INSTR_WIDTH-1 -: 2];

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    issue_d    = 1'b0;
    halt_lat_d = halt_lat_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          halt_lat_d = 1'b0;
          pc_d       = '0;
          if (fetch_type == 2'b00) begin
            state_d = S_HALTED;
            instr_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_RUN;
            instr_d = fetch_word;
            // Extra cycle absorbs the CU's RESET->DECODE transition on the first word only.
            cnt_d   = hold_of(fetch_type) + CNT_W'(1);
            issue_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d      = cnt_q - CNT_W'(1);
          halt_lat_d = halt_lat_q | halt;
        end else if (halt || halt_lat_q) begin
          state_d    = S_HALTED;
          instr_d    = '0;
          cnt_d      = '0;
          halt_lat_d = 1'b0;
        end else if (!WRAP_EN && (&pc_q)) begin
          state_d    = S_HALTED;
          instr_d    = '0;
          cnt_d      = '0;
          halt_lat_d = 1'b0;
        end else if (fetch_type == 2'b00) begin
          state_d    = S_HALTED;
          instr_d    = '0;
          pc_d       = next_pc;
          cnt_d      = '0;
          halt_lat_d = 1'b0;
        end else begin
          instr_d = fetch_word;
          pc_d    = next_pc;
          cnt_d   = hold_of(fetch_type);
          issue_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
      issue_q    <= 1'b0;
      halt_lat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      issue_q    <= issue_d;
      halt_lat_q <= halt_lat_d;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign issue       = issue_q;
  assign busy        = (state_q == S_RUN);
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hold lengths per type, halt latching, reset abort,
// program-load gating and end-of-memory handling (both FETCH_WRAP_EN builds).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        prog_wen;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic [19:0] instruction;
  logic [4:0]  pc;
  logic        issue;
  logic        busy;
  logic        halted;

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .prog_wen    (prog_wen),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instruction (instruction),
    .pc          (pc),
    .issue       (issue),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    prog_wen  = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_wen  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called on the cycle after the issuing edge; leaves time at the last hold cycle.
  task automatic expect_word(input string tag, input logic [19:0] w, input logic [4:0] p, input int n);
    check({tag, ".issue"}, 32'(issue), 32'd1);
    check({tag, ".instr"}, 32'(instruction), 32'(w));
    check({tag, ".pc"}, 32'(pc), 32'(p));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 1; i < n; i++) begin
      step();
      check($sformatf("%s.hold%0d.instr", tag, i), 32'(instruction), 32'(w));
      check($sformatf("%s.hold%0d.issue", tag, i), 32'(issue), 32'd0);
      check($sformatf("%s.hold%0d.pc", tag, i), 32'(pc), 32'(p));
    end
  endtask

  task automatic expect_halted(input string tag, input logic [4:0] p);
    check({tag, ".halted"}, 32'(halted), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".instr"}, 32'(instruction), 32'd0);
    check({tag, ".pc"}, 32'(pc), 32'(p));
    check({tag, ".issue"}, 32'(issue), 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; halt = 1'b0;
    prog_wen = 1'b0; prog_addr = '0; prog_data = '0;
    step();
    step();
    check("rst.instr", 32'(instruction), 32'd0);
    check("rst.pc", 32'(pc), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.issue", 32'(issue), 32'd0);
    rst = 1'b1;
    step();
    $display("[TB] reset checked");

    // T2: single std_op then end marker
    load(5'd0, 20'h56000);
    load(5'd1, 20'h00000);
    do_start();
    expect_word("t2.w0", 20'h56000, 5'd0, 4);
    step();
    expect_halted("t2.end", 5'd1);
    $display("[TB] T2 done");

    // T3: load then store, runs off into end marker at address 2
    load(5'd0, 20'h84050);
    load(5'd1, 20'hC4050);
    load(5'd2, 20'h00000);
    do_start();
    expect_word("t3.w0", 20'h84050, 5'd0, 5);
    step();
    expect_word("t3.w1", 20'hC4050, 5'd1, 3);
    step();
    expect_halted("t3.end", 5'd2);
    $display("[TB] T3 done");

    // T4: one-cycle halt pulse on 2nd cycle of the first word; also a stray start in RUN
    do_start();
    check("t4.c1.instr", 32'(instruction), 32'h84050);
    step();
    halt = 1'b1;
    start = 1'b1;
    step();
    halt = 1'b0;
    start = 1'b0;
    check("t4.c3.instr", 32'(instruction), 32'h84050);
    check("t4.c3.pc", 32'(pc), 32'd0);
    step();
    step();
    check("t4.c5.instr", 32'(instruction), 32'h84050);
    check("t4.c5.busy", 32'(busy), 32'd1);
    step();
    expect_halted("t4.end", 5'd0);
    $display("[TB] T4 done");

    // T1: reset mid-run takes effect without a clock edge
    do_start();
    step();
    #2;
    rst = 1'b0;
    #1;
    check("t1.instr", 32'(instruction), 32'd0);
    check("t1.pc", 32'(pc), 32'd0);
    check("t1.busy", 32'(busy), 32'd0);
    check("t1.halted", 32'(halted), 32'd0);
    check("t1.issue", 32'(issue), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("t1.idle.busy", 32'(busy), 32'd0);
    check("t1.idle.halted", 32'(halted), 32'd0);
    $display("[TB] T1 done");

    // T6: program write during RUN is dropped, the same write while halted lands
    load(5'd0, 20'h56000);
    load(5'd1, 20'h84050);
    load(5'd2, 20'h00000);
    do_start();
    check("t6.r1.instr", 32'(instruction), 32'h56000);
    prog_wen = 1'b1; prog_addr = 5'd1; prog_data = 20'hC4050;
    step();
    prog_wen = 1'b0;
    step();
    step();
    step();
    expect_word("t6.r1.w1", 20'h84050, 5'd1, 4);
    step();
    expect_halted("t6.r1.end", 5'd2);
    load(5'd1, 20'hC4050);
    // start and halt together: start wins, no stale halt carried into the run
    halt = 1'b1;
    do_start();
    halt = 1'b0;
    expect_word("t6.r2.w0", 20'h56000, 5'd0, 4);
    step();
    expect_word("t6.r2.w1", 20'hC4050, 5'd1, 3);
    step();
    expect_halted("t6.r2.end", 5'd2);
    $display("[TB] T6 done");

    // T5: every word a std_op, runs to the top of memory
    for (int a = 0; a < 32; a++) load(5'(a), 20'h56000);
    do_start();
    for (int a = 0; a < 32; a++) begin
      expect_word($sformatf("t5.w%0d", a), 20'h56000, 5'(a), (a == 0) ? 4 : 3);
      step();
    end
`ifdef FETCH_WRAP_EN
    expect_word("t5.wrap", 20'h56000, 5'd0, 3);
`else
    expect_halted("t5.end", 5'd31);
`endif
    $display("[TB] T5 done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
